mfp_uart_rx_buffered: RTL and testbench

Oversampling UART receiver with a small byte FIFO. It feeds the SREC parser in the serial-load path. It samples `UART_RX` at 16x baud, rejects start-bit glitches, takes a majority vote per bit, and flags framing and overrun errors. Received bytes are presented to the parser as single-cycle `byte_ready` pulses, and `byte_hold` lets the downstream bridge stall delivery without losing data.

---
 rtl/mfp_uart_rx_buffered_pkg.sv | 39 +++
 rtl/mfp_uart_byte_fifo.sv | 57 +++++
 rtl/mfp_uart_rx_buffered.sv | 180 ++++++++++++++++++
 tb/tb_mfp_uart_rx_buffered.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mfp_uart_rx_buffered_pkg.sv
// Shared constants and helpers for the buffered UART receiver.
//   - default line parameters and the 16x oversample factor
//   - receive FSM state type
//   - baud divisor and 3-way majority helpers
// State encodings keep their original 3-bit values so older traces still decode.
package mfp_uart_rx_buffered_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD   = 115_200;
  localparam int unsigned OVERSAMPLE     = 16;

  // Per-bit sample points in oversample ticks; the vote happens on the last one.
  localparam logic [3:0] SMP_FIRST  = 4'd7;
  localparam logic [3:0] SMP_SECOND = 4'd8;
  localparam logic [3:0] SMP_VOTE   = 4'd9;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  // round(clk_hz / (baud * 16)), computed wide to avoid overflow.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'(clk_hz) + 64'(baud) * 64'(OVERSAMPLE / 2);
    den = 64'(baud) * 64'(OVERSAMPLE);
    return 32'(num / den);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mfp_uart_byte_fifo.sv
// DEPTH x 8-bit synchronous FIFO.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push/push_data : write request; ignored when full unless a pop happens too
//   pop            : read request; ignored when empty
//   pop_data       : head entry (combinational, valid while not empty)
//   count          : occupancy 0..DEPTH
//   full, empty    : occupancy flags
module mfp_uart_byte_fifo
  import mfp_uart_rx_buffered_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full     = (count == (AW + 1)'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop && !empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    do_push  = push && (!full || do_pop);
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/mfp_uart_rx_buffered.sv
// 16x oversampling UART receiver (8N1) with a byte FIFO in front of the parser.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   UART_RX       : asynchronous serial input, idles high
//   byte_hold     : stalls delivery while high
//   err_clear     : pulse clearing the sticky error flags
//   byte_data     : last delivered byte, held between deliveries
//   byte_ready    : one-cycle delivery strobe, byte_data valid alongside
//   framing_error : sticky, stop bit voted 0
//   overrun       : sticky, byte arrived with the FIFO full and no pop
//   fifo_count    : FIFO occupancy
module mfp_uart_rx_buffered
  import mfp_uart_rx_buffered_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned BAUD   = DEFAULT_BAUD,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   UART_RX,
  input  logic                   byte_hold,
  input  logic                   err_clear,
  output logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   framing_error,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned    DIV      = baud_div(CLK_HZ, BAUD);
  localparam int unsigned    CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  // Input synchroniser; reset high so a released reset does not look like a start bit.
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  rx_state_t        state;
  logic [3:0]       smp;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             samp_a;
  logic             samp_b;
  logic [CNT_W-1:0] div_cnt;

  logic start_det;
  logic tick;
  logic sampling;
  logic vote_tick;
  logic vote_bit;
  logic rx_push;
  logic framing_set;
  logic overrun_set;

  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic [7:0] fifo_dout;

  always_comb begin
    start_det   = (state == RX_IDLE) && !rx_s;
    tick        = (div_cnt == CNT_LAST);
    sampling    = (state == RX_START) || (state == RX_DATA) || (state == RX_STOP);
    vote_tick   = sampling && tick && (smp == SMP_VOTE);
    vote_bit    = maj3(samp_a, samp_b, rx_s);
    rx_push     = vote_tick && (state == RX_STOP) && vote_bit;
    framing_set = vote_tick && (state == RX_STOP) && !vote_bit;
    pop         = !fifo_empty && !byte_hold;
    overrun_set = rx_push && fifo_full && !pop;
  end

  // Tick generator, restarted on the start edge so samples sit at a fixed bit phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt <= '0;
    end else if (start_det || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= RX_IDLE;
      smp     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
    end else begin
      if (sampling && tick) begin
        smp <= smp + 1'b1;  // wraps 15 -> 0 at each bit boundary
        if (smp == SMP_FIRST)  samp_a <= rx_s;
        if (smp == SMP_SECOND) samp_b <= rx_s;
      end
      unique case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state <= RX_START;
            smp   <= '0;
          end
        end
        RX_START: begin
          if (vote_tick) begin
            if (!vote_bit) begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (vote_tick) begin
            shreg   <= {vote_bit, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Leave half a bit early on a good stop so the next start edge is not missed.
          if (vote_tick) state <= vote_bit ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  mfp_uart_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .push     (rx_push),
    .push_data(shreg),
    .pop      (pop),
    .pop_data (fifo_dout),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      byte_data  <= '0;
      byte_ready <= 1'b0;
    end else begin
      byte_ready <= pop;
      if (pop) byte_data <= fifo_dout;
    end
  end

  // Sticky flags: a set in the same cycle as err_clear wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (framing_set)    framing_error <= 1'b1;
      else if (err_clear) framing_error <= 1'b0;
      if (overrun_set)    overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mfp_uart_rx_buffered.sv
// Bench for mfp_uart_rx_buffered at a reduced line rate (divisor 6, 96 clocks per bit).
module tb_mfp_uart_rx_buffered;

  localparam int unsigned BIT_C = 96;
  localparam int unsigned FRAME_C = BIT_C * 10;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       UART_RX;
  logic       byte_hold;
  logic       err_clear;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       framing_error;
  logic       overrun;
  logic [4:0] fifo_count;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [7:0] exp_q[$];

  always #5 HCLK = ~HCLK;

  mfp_uart_rx_buffered #(
    .CLK_HZ(96_000_000),
    .BAUD  (1_000_000),
    .DEPTH (16)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .UART_RX      (UART_RX),
    .byte_hold    (byte_hold),
    .err_clear    (err_clear),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .framing_error(framing_error),
    .overrun      (overrun),
    .fifo_count   (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every delivered byte must match the oldest outstanding expectation.
  always @(negedge HCLK) begin
    if (HRESETn === 1'b1 && byte_ready === 1'b1) begin
      check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("byte_data", 32'(byte_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic line_for(input logic v, input int unsigned cycles);
    UART_RX = v;
    repeat (cycles) @(negedge HCLK);
  endtask

  task automatic send_byte(input logic [7:0] d, input int unsigned bitc,
                           input logic stop_bit, input bit expect_it);
    logic [7:0] b;
    b = d;
    if (expect_it) exp_q.push_back(d);
    line_for(1'b0, bitc);
    for (int i = 0; i < 8; i++) line_for(b[i], bitc);
    line_for(stop_bit, bitc);
    UART_RX = 1'b1;
  endtask

  task automatic drain(input string tag);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_count != 0) && n < 5000) begin
      @(negedge HCLK);
      n++;
    end
    repeat (4) @(negedge HCLK);
    check({tag, "_drained"}, 32'(exp_q.size() == 0 && fifo_count == 0), 32'd1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned run;
    HRESETn = 1'b0;
    UART_RX = 1'b1;
    byte_hold = 1'b0;
    err_clear = 1'b0;
    repeat (4) @(negedge HCLK);
    check("rst_data", 32'(byte_data), 32'd0);
    check("rst_flags", 32'({byte_ready, framing_error, overrun}), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    HRESETn = 1'b1;
    repeat (20) @(negedge HCLK);

    // Single byte
    send_byte(8'hA5, BIT_C, 1'b1, 1'b1);
    drain("single");
    check("single_errs", 32'({framing_error, overrun}), 32'd0);

    // Start glitch: 4 ticks low
    line_for(1'b0, 24);
    line_for(1'b1, 2 * FRAME_C);
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_errs", 32'({framing_error, overrun}), 32'd0);

    // Overrun: 20 bytes while held, only the first 16 survive
    byte_hold = 1'b1;
    for (int i = 0; i < 20; i++) send_byte(8'(i), BIT_C, 1'b1, i < 16);
    repeat (BIT_C) @(negedge HCLK);
    check("ovr_count", 32'(fifo_count), 32'd16);
    check("ovr_flag", 32'(overrun), 32'd1);
    byte_hold = 1'b0;
    run = 0;
    for (int i = 0; i < 5 && byte_ready !== 1'b1; i++) @(negedge HCLK);
    while (byte_ready === 1'b1 && run < 40) begin
      run++;
      @(negedge HCLK);
    end
    check("ovr_burst_len", run, 32'd16);
    drain("ovr");

    // Reset in the middle of 0x81 (asserted in bit 2, released in bit 7 which is high)
    fork
      send_byte(8'h81, BIT_C, 1'b1, 1'b0);
      begin
        repeat (3 * BIT_C + 48) @(negedge HCLK);
        HRESETn = 1'b0;
        repeat (5) @(negedge HCLK);
        check("midrst_data", 32'(byte_data), 32'd0);
        check("midrst_flags", 32'({byte_ready, framing_error, overrun}), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        repeat (460) @(negedge HCLK);
        HRESETn = 1'b1;
      end
    join
    repeat (2 * BIT_C) @(negedge HCLK);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    send_byte(8'h7E, BIT_C, 1'b1, 1'b1);
    drain("post_rst");

    // Framing error followed by a held-low line
    send_byte(8'h3C, BIT_C, 1'b0, 1'b0);
    line_for(1'b0, 3 * BIT_C);
    line_for(1'b1, 2 * BIT_C);
    check("fe_flag", 32'(framing_error), 32'd1);
    check("fe_count", 32'(fifo_count), 32'd0);
    send_byte(8'h55, BIT_C, 1'b1, 1'b1);
    drain("fe_recover");
    check("fe_sticky", 32'(framing_error), 32'd1);
    err_clear = 1'b1;
    @(negedge HCLK);
    err_clear = 1'b0;
    @(negedge HCLK);
    check("fe_cleared", 32'(framing_error), 32'd0);

    // Baud skew: +3% (93 clocks/bit) and -3% (99 clocks/bit)
    for (int i = 0; i < 12; i++) send_byte(8'($urandom_range(0, 255)), 93, 1'b1, 1'b1);
    drain("skew_fast");
    for (int i = 0; i < 12; i++) send_byte(8'($urandom_range(0, 255)), 99, 1'b1, 1'b1);
    drain("skew_slow");
    check("final_errs", 32'({framing_error, overrun}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
